// File: rtl/stream_palindrome_pkg.sv
// Shared types and helpers for the streaming palindrome checker.
package stream_palindrome_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CHECK  = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Reverses the low w bits of v (w <= 64); bits above w come back as zero.
  function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = {<<{v}};
    return r >> (64 - w);
  endfunction

endpackage

// File: rtl/palin_buf.sv
// Frame buffer: one write port, two combinational read ports, no reset.
module palin_buf #(
  parameter int SYM_W  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] lo_addr,
  input  logic [ADDR_W-1:0] hi_addr,
  output logic [SYM_W-1:0]  lo_data,
  output logic [SYM_W-1:0]  hi_data
);

  logic [SYM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign lo_data = mem[lo_addr];
  assign hi_data = mem[hi_addr];

endmodule

// File: rtl/stream_palindrome_checker.sv
// Buffers a symbol frame, then walks inward one mirror pair per cycle and
// reports whether the frame reads the same from both ends.
module stream_palindrome_checker
  import stream_palindrome_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int BIT_REV = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SYM_W-1:0]                 in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_palin,
  output logic [$clog2(MAX_LEN+1)-1:0]     out_len,
  output logic                             out_ovf
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  state_t state, state_next;

  logic [LEN_W-1:0] cnt, lo, hi;
  logic             ovf, palin;
  logic [SYM_W-1:0] lo_sym, hi_sym, mirror;
  logic             accept, full, wr_en;
  logic             pair_eq, last_pair, odd_final, mid_ok;

  assign accept = in_valid && in_ready;
  assign full   = (cnt == MAX_CNT);
  assign wr_en  = accept && !full;

  palin_buf #(
    .SYM_W  (SYM_W),
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt[ADDR_W-1:0]),
    .wr_data (in_data),
    .lo_addr (lo[ADDR_W-1:0]),
    .hi_addr (hi[ADDR_W-1:0]),
    .lo_data (lo_sym),
    .hi_data (hi_sym)
  );

  assign mirror  = (BIT_REV != 0) ? SYM_W'(bit_reverse(64'(hi_sym), SYM_W)) : hi_sym;
  assign pair_eq = (lo_sym == mirror);

  // lo+1 >= hi-1 rewritten as lo+2 >= hi so hi=0 cannot underflow
  assign last_pair = (lo >= hi) || (({1'b0, lo} + (LEN_W+1)'(2)) >= {1'b0, hi});
  assign odd_final = (({1'b0, lo} + (LEN_W+1)'(2)) == {1'b0, hi});

  // With bit reversal the untouched middle symbol of an odd frame must equal
  // its own reverse; that property is captured per slot as symbols arrive.
  if (BIT_REV != 0) begin : g_mid
    logic              mid_sym [MAX_LEN];
    logic [ADDR_W-1:0] mid_idx;

    always_ff @(posedge clk) begin
      if (wr_en) mid_sym[cnt[ADDR_W-1:0]] <= (in_data == SYM_W'(bit_reverse(64'(in_data), SYM_W)));
    end

    assign mid_idx = lo[ADDR_W-1:0] + ADDR_W'(1);
    assign mid_ok  = mid_sym[mid_idx];
  end else begin : g_no_mid
    assign mid_ok = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (accept && in_last) state_next = (ovf || full) ? RESULT : CHECK;
      CHECK:   if (!pair_eq || last_pair) state_next = RESULT;
      RESULT:  if (out_ready) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == RESULT);
    out_palin = (state == RESULT) ? palin : 1'b0;
    out_len   = (state == RESULT) ? cnt : '0;
    out_ovf   = (state == RESULT) ? ovf : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      lo    <= '0;
      hi    <= '0;
      ovf   <= 1'b0;
      palin <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (!full) cnt <= cnt + LEN_W'(1);
            ovf <= ovf || full;
            if (in_last) begin
              lo    <= '0;
              hi    <= cnt;
              palin <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (!pair_eq) begin
            palin <= 1'b0;
          end else if (last_pair) begin
            palin <= odd_final ? mid_ok : 1'b1;
          end else begin
            lo <= lo + LEN_W'(1);
            hi <= hi - LEN_W'(1);
          end
        end
        RESULT: begin
          if (out_ready) begin
            cnt   <= '0;
            ovf   <= 1'b0;
            palin <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_palindrome_checker.sv
// Scoreboard bench: two instances (plain and bit-reversed compare) driven by
// directed frames; a negedge monitor pops expected results and checks them.
module tb_stream_palindrome_checker;

  typedef struct {
    logic       palin;
    logic [4:0] len;
    logic       ovf;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic iv = 1'b0, il = 1'b0, orr = 1'b1;
  logic [7:0] id = 8'h00;
  int sel = 0;

  logic [1:0] ir, ov, op, oo;
  logic [4:0] ol [2];

  int total = 0, bad = 0, cyc = 0;
  int hs_cyc [2];
  bit seen [2];
  logic hp [2], ho [2];
  logic [4:0] hl [2];
  logic [7:0] fr [0:31];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_palindrome_checker #(.SYM_W(8), .MAX_LEN(16), .BIT_REV(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv && (sel == 0)), .in_ready(ir[0]), .in_data(id), .in_last(il),
    .out_valid(ov[0]), .out_ready(orr), .out_palin(op[0]), .out_len(ol[0]), .out_ovf(oo[0])
  );

  stream_palindrome_checker #(.SYM_W(8), .MAX_LEN(16), .BIT_REV(1)) dut_br (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv && (sel == 1)), .in_ready(ir[1]), .in_data(id), .in_last(il),
    .out_valid(ov[1]), .out_ready(orr), .out_palin(op[1]), .out_len(ol[1]), .out_ovf(oo[1])
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int k);
    exp_t e;
    int   n;
    if (ov[k]) begin
      if (!seen[k]) begin
        seen[k] = 1'b1;
        n = (k == 0) ? q0.size() : q1.size();
        if (n == 0) begin
          chk($sformatf("unexpected_result%0d", k), 1, 0);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("palin%0d", k), op[k], e.palin);
          chk($sformatf("len%0d", k), ol[k], e.len);
          chk($sformatf("ovf%0d", k), oo[k], e.ovf);
          chk($sformatf("latency%0d", k), cyc - hs_cyc[k] + 1, e.lat);
        end
        hp[k] = op[k];
        hl[k] = ol[k];
        ho[k] = oo[k];
      end else begin
        chk($sformatf("hold_palin%0d", k), op[k], hp[k]);
        chk($sformatf("hold_len%0d", k), ol[k], hl[k]);
        chk($sformatf("hold_ovf%0d", k), oo[k], ho[k]);
      end
      chk($sformatf("in_ready_in_result%0d", k), ir[k], 0);
      if (orr) seen[k] = 1'b0;
    end else begin
      chk($sformatf("idle_outputs%0d", k), {op[k], oo[k], ol[k]}, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  // Sends fr[0..n-1] to instance k and queues the expected result.
  task automatic send(input int k, input int n, input logic p, input logic [4:0] len,
                      input logic ovf, input int lat);
    exp_t e;
    int   t;
    e = '{palin: p, len: len, ovf: ovf, lat: lat};
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    sel = k;
    for (int i = 0; i < n; i++) begin
      iv = 1'b1;
      id = fr[i];
      il = (i == n - 1);
      t = 0;
      while (!ir[k] && t < 100) begin
        step();
        t++;
      end
      if (t >= 100) chk("in_ready_timeout", 0, 1);
      step();
    end
    hs_cyc[k] = cyc;
    iv = 1'b0;
    il = 1'b0;
  endtask

  task automatic sendh(input int k, input int n, input logic [127:0] bytes, input logic p,
                       input logic [4:0] len, input logic ovf, input int lat);
    for (int i = 0; i < n; i++) fr[i] = 8'(bytes >> (8 * (n - 1 - i)));
    send(k, n, p, len, ovf, lat);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || seen[0] || seen[1]) && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) chk("result_timeout", 0, 1);
  endtask

  initial begin
    int t;
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    hs_cyc[0] = 0;
    hs_cyc[1] = 0;

    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_in_ready%0d", k), ir[k], 1);
      chk($sformatf("rst_out_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_outputs%0d", k), {op[k], oo[k], ol[k]}, 0);
    end
    step();
    step();
    rst_n = 1'b1;
    step();

    sendh(0, 5, 128'h0102030201, 1'b1, 5'd5, 1'b0, 3);
    wait_idle();
    sendh(0, 4, 128'h01020304, 1'b0, 5'd4, 1'b0, 2);
    wait_idle();
    sendh(0, 1, 128'hA5, 1'b1, 5'd1, 1'b0, 2);
    wait_idle();
    sendh(0, 6, 128'h010203090201, 1'b0, 5'd6, 1'b0, 4);
    wait_idle();

    // Exactly MAX_LEN symbols, palindromic: no overflow, 8 compare cycles.
    for (int i = 0; i < 8; i++) begin
      fr[i] = 8'(i + 1);
      fr[15 - i] = 8'(i + 1);
    end
    send(0, 16, 1'b1, 5'd16, 1'b0, 9);
    wait_idle();

    for (int i = 0; i < 17; i++) fr[i] = 8'h00;
    send(0, 17, 1'b0, 5'd16, 1'b1, 1);
    wait_idle();
    for (int i = 0; i < 19; i++) fr[i] = 8'(i);
    send(0, 19, 1'b0, 5'd16, 1'b1, 1);
    wait_idle();

    // Backpressure: result held for 5 cycles while junk input is offered.
    orr = 1'b0;
    sendh(0, 2, 128'h0505, 1'b1, 5'd2, 1'b0, 2);
    t = 0;
    while (!ov[0] && t < 50) begin
      step();
      t++;
    end
    chk("bp_result_seen", ov[0], 1);
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1;
      id = 8'hAA;
      il = 1'b1;
      step();
      chk("bp_in_ready", ir[0], 0);
      chk("bp_out_valid", ov[0], 1);
    end
    iv = 1'b0;
    il = 1'b0;
    orr = 1'b1;
    step();
    chk("bp_release_in_ready", ir[0], 1);
    chk("bp_release_out_valid", ov[0], 0);
    wait_idle();

    // Reset while walking a 16-symbol frame: no result may appear.
    for (int i = 0; i < 8; i++) begin
      fr[i] = 8'(8'h10 + i);
      fr[15 - i] = 8'(8'h10 + i);
    end
    send(0, 16, 1'b1, 5'd16, 1'b0, 9);
    step();
    step();
    chk("pre_reset_in_ready", ir[0], 0);
    rst_n = 1'b0;
    #1;
    chk("midcheck_rst_out_valid", ov[0], 0);
    chk("midcheck_rst_in_ready", ir[0], 1);
    q0.delete();
    seen[0] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    sendh(0, 2, 128'h0707, 1'b1, 5'd2, 1'b0, 2);
    wait_idle();

    // Bit-reversed mirror compare instance.
    sendh(1, 1, 128'h81, 1'b1, 5'd1, 1'b0, 2);
    wait_idle();
    sendh(1, 1, 128'h01, 1'b0, 5'd1, 1'b0, 2);
    wait_idle();
    sendh(1, 3, 128'h0F18F0, 1'b1, 5'd3, 1'b0, 2);
    wait_idle();
    sendh(1, 3, 128'h0F10F0, 1'b0, 5'd3, 1'b0, 2);
    wait_idle();
    sendh(1, 2, 128'h0180, 1'b1, 5'd2, 1'b0, 2);
    wait_idle();

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, want 0");
    $fatal(1, "timeout");
  end

endmodule
